instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetches 16-bit instructions from a synchronous-read program memory and issues them one at a time to the datapath controller over the controller's `s`/`w` start/wait handshake. It owns the program counter and instruction register. It presents the decoded `opcode`/`op` fields to the controller and stops on a halt instruction or a handshake timeout. It sits between program memory and the controller, driving the controller's `s`, `opcode` and `op` inputs.

## Interface
- `START_ADDR`, 8'h00, PC value loaded on reset and on every accepted `go`.
- `TIMEOUT`, 64, maximum cycles allowed from `s` pulse to `w` returning high; range 2..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on rising edge of `clk`.
- `go`  in  1  start request; sampled only in IDLE, HALTED or ERROR.
- `w`  in  1  controller wait/ready: 1 = controller idle and able to accept `s`.
- `mem_rdata`  in  16  program memory read data; valid the cycle after `mem_rd`.
- `mem_addr`  out  8  program memory address, always equal to `PC`.
- `mem_rd`  out  1  memory read strobe.
- `s`  out  1  start pulse to controller.
- `instr`  out  16  instruction register.
- `opcode`  out  3  `instr[15:13]`.
- `op`  out  2  `instr[12:11]`.
- `PC`  out  8  program counter.
- `icount`  out  8  count of completed instructions, wraps at 255→0.
- `busy`  out  1  1 in any state other than IDLE, HALTED or ERROR.
- `halted`  out  1  1 in HALTED.
- `err`  out  1  1 in ERROR.

## Operation
- States: IDLE, FETCH, CAPTURE, ISSUE, ACK, DONE, HALTED, ERROR.
- Reset (any state, including mid-handshake) enters IDLE with these values:
  - `PC` = START_ADDR; `instr` = 0; `icount` = 0; timer = 0.
  - `s`, `mem_rd`, `busy`, `halted` and `err` all 0.
- IDLE / HALTED / ERROR:
  - `go`=1 → FETCH.
  - On that transition: `PC` ← START_ADDR, `icount` ← 0, `err` and `halted` clear.
  - `go` in any other state is ignored.
- FETCH: `mem_rd`=1 → CAPTURE.
- CAPTURE: `instr` ← `mem_rdata`.
  - If `mem_rdata[15:13]`=3'b111 (halt): → HALTED; `s` is never asserted for it; `PC` is left pointing at the halt word.
  - Otherwise: → ISSUE.
- ISSUE: entered and held only while `w`=1.
  - If `w`=0 on entry into the ISSUE decision, wait in CAPTURE-hold with the timer running.
  - `s`=1 for exactly one cycle, then → ACK. Timer cleared to 0 on the `s` cycle.
- ACK: `s`=0; wait for `w`=0, then → DONE.
- DONE: wait for `w`=1. On `w`=1:
  - `PC` ← `PC`+1, modulo 256 (8'hFF wraps to 8'h00).
  - `icount` ← `icount`+1.
  - → FETCH.
- Timer: increments every cycle in ACK, DONE and CAPTURE-hold. Reaching TIMEOUT → ERROR, `err`=1.
- `opcode` and `op` are combinational slices of `instr`. All other outputs are registered or decoded from the state register only; there is no combinational path from `w` or `mem_rdata` to `s`.
- `s` is a strictly single-cycle pulse. This guarantees the controller never re-samples `s` after an invalid-opcode bounce back to its waiting state.

## Timing
- `go` sampled at edge 0:
  - FETCH during cycle 1.
  - `mem_rdata` captured at edge 2.
  - `s` high during cycle 3 (when `w`=1).
- Controller samples `s` at edge 4; `w` falls after edge 4; ACK exits at edge 5.
- Minimum issue-to-next-fetch latency is controller execution length + 2 cycles.
- Steady-state overhead per instruction: 4 cycles (FETCH, CAPTURE, ISSUE, DONE exit) plus controller busy time.
- `halted` rises the cycle after CAPTURE of a halt word.
- `err` rises the cycle after the timer reaches TIMEOUT.
- A `go` coincident with `reset` is ignored; reset wins.

## Test plan
- Program [0]=16'hD007 (MOV R0,#7), [1]=16'hE000 (halt); bench controller model returns `w`=1 two cycles after `s`:
  - exactly one `s` pulse, with `opcode`=3'b110 and `op`=2'b10 during it;
  - then `halted`=1, `PC`=1, `icount`=1, `busy`=0.
- Three ALU instructions (16'hA000, 16'hA800, 16'hB800) then halt:
  - three single-cycle `s` pulses, each issued only while `w`=1;
  - final `icount`=3, `PC`=3.
- Bench holds `w`=1 forever after `s` (no ack), TIMEOUT=8:
  - `err`=1 nine cycles after the `s` pulse; `s` not re-asserted;
  - a following `go` clears `err` and refetches from START_ADDR.
- START_ADDR=8'hFE, halt placed at address 8'h01:
  - `PC` sequence FE, FF, 00, 01; `halted` with `icount`=3.
- `reset` asserted during ACK:
  - next cycle: IDLE, `s`=0, `PC`=START_ADDR, `icount`=0;
  - no further `mem_rd` until `go`.
- `go` pulsed while `busy`=1: no effect on `PC` or `icount`, and no extra `s`.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words from synchronous program memory and issues
// them to the datapath controller over the s/w start/wait handshake.
module instr_sequencer #(
  parameter logic [7:0]  START_ADDR = 8'h00,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        w,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        s,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [7:0]  PC,
  output logic [7:0]  icount,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StCapture, StHold, StIssue, StAck, StDone, StHalted, StError
  } state_e;

  // Timer value whose increment would reach TIMEOUT.
  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  icount_q, icount_d;
  logic [7:0]  timer_q, timer_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    icount_d = icount_q;
    timer_d  = timer_q;
    unique case (state_q)
      StIdle, StHalted, StError: begin
        if (go) begin
          state_d  = StFetch;
          pc_d     = START_ADDR;
          icount_d = 8'd0;
          timer_d  = 8'd0;
        end
      end
      StFetch: begin
        timer_d = 8'd0;
        state_d = StCapture;
      end
      StCapture: begin
        instr_d = mem_rdata;
        if (mem_rdata[15:13] == 3'b111) begin
          state_d = StHalted;
        end else if (w) begin
          state_d = StIssue;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        timer_d = timer_q + 8'd1;
        if (w) begin
          state_d = StIssue;
        end else if (timer_q == TimerLast) begin
          state_d = StError;
        end
      end
      StIssue: begin
        timer_d = 8'd0;
        state_d = StAck;
      end
      StAck: begin
        timer_d = timer_q + 8'd1;
        if (!w) begin
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          state_d = StError;
        end
      end
      StDone: begin
        timer_d = timer_q + 8'd1;
        if (w) begin
          pc_d     = pc_q + 8'd1;
          icount_d = icount_q + 8'd1;
          state_d  = StFetch;
        end else if (timer_q == TimerLast) begin
          state_d = StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= START_ADDR;
      instr_q  <= 16'h0000;
      icount_q <= 8'd0;
      timer_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      icount_q <= icount_d;
      timer_q  <= timer_d;
    end
  end

  // Everything but opcode/op decodes from registers, so s never depends on w combinationally.
  assign mem_addr = pc_q;
  assign PC       = pc_q;
  assign instr    = instr_q;
  assign icount   = icount_q;
  assign opcode   = instr_q[15:13];
  assign op       = instr_q[12:11];
  assign mem_rd   = (state_q == StFetch);
  assign s        = (state_q == StIssue);
  assign halted   = (state_q == StHalted);
  assign err      = (state_q == StError);
  assign busy     = !((state_q == StIdle) || (state_q == StHalted) || (state_q == StError));

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program memory and controller models, with queues of
// expected fetch addresses and issued opcode/op fields checked as the DUT produces them.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, go, w;
  logic [15:0] mem_rdata, instr;
  logic [7:0]  mem_addr, pc, icount;
  logic        mem_rd, s, busy, halted, err;
  logic [2:0]  opcode;
  logic [1:0]  op;

  logic        w_model, hold_low, ack_en;
  logic [1:0]  ack_cnt;
  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  int s_count = 0;
  int s_base;
  logic s_prev = 1'b0;
  logic [4:0] exp_issue_q[$];
  logic [7:0] exp_fetch_q[$];

  instr_sequencer #(
    .START_ADDR(8'hFE),
    .TIMEOUT   (8)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .w        (w),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .s        (s),
    .instr    (instr),
    .opcode   (opcode),
    .op       (op),
    .PC       (pc),
    .icount   (icount),
    .busy     (busy),
    .halted   (halted),
    .err      (err)
  );

  always #5 clk = ~clk;

  assign w = w_model & ~hold_low;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Controller model: drops w when it samples s, raises it again two cycles later.
  always @(posedge clk) begin
    if (reset) begin
      w_model <= 1'b1;
      ack_cnt <= 2'd0;
    end else if (ack_en && s) begin
      w_model <= 1'b0;
      ack_cnt <= 2'd2;
    end else if (ack_cnt != 2'd0) begin
      ack_cnt <= ack_cnt - 2'd1;
      if (ack_cnt == 2'd1) w_model <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d);
    mem[8'hFE] = a;
    mem[8'hFF] = b;
    mem[8'h00] = c;
    mem[8'h01] = d;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_s(input int budget);
    int n = 0;
    while (s !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("s_seen", s, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(halted === 1'b1 || err === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset    = 1'b1;
    go       = 1'b1;
    hold_low = 1'b0;
    ack_en   = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (s) begin
          check("s_single_cycle", s_prev, 0);
          check("s_w_high", w, 1);
          if (exp_issue_q.size() == 0) check("s_unexpected", s, 0);
          else check("s_opcode_op", {opcode, op}, exp_issue_q.pop_front());
          s_count++;
        end
        if (mem_rd) begin
          if (exp_fetch_q.size() == 0) check("fetch_unexpected", mem_rd, 0);
          else check("fetch_addr", mem_addr, exp_fetch_q.pop_front());
        end
        s_prev = s;
      end
    join_none

    // Reset with coincident go: reset wins.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    go    = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, 8'hFE);
    check("rst_instr", instr, 16'h0000);
    check("rst_icount", icount, 0);
    check("rst_s", s, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);

    // Single MOV then halt.
    load_prog(16'hD007, 16'hE000, 16'h0000, 16'h0000);
    exp_fetch_q.push_back(8'hFE);
    exp_fetch_q.push_back(8'hFF);
    exp_issue_q.push_back({3'b110, 2'b10});
    s_base = s_count;
    pulse_go();
    wait_done(60);
    check("t1_pc", pc, 8'hFF);
    check("t1_icount", icount, 1);
    check("t1_busy", busy, 0);
    check("t1_instr", instr, 16'hE000);
    check("t1_s_pulses", s_count - s_base, 1);
    check("t1_queues", exp_fetch_q.size() + exp_issue_q.size(), 0);

    // Three ALU ops across the FF->00 wrap, w held low at first, stray go while busy.
    load_prog(16'hA000, 16'hA800, 16'hB800, 16'hE000);
    exp_fetch_q.push_back(8'hFE);
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h00);
    exp_fetch_q.push_back(8'h01);
    exp_issue_q.push_back({3'b101, 2'b00});
    exp_issue_q.push_back({3'b101, 2'b01});
    exp_issue_q.push_back({3'b101, 2'b11});
    hold_low = 1'b1;
    s_base   = s_count;
    pulse_go();
    repeat (5) @(negedge clk);
    check("t2_hold_busy", busy, 1);
    check("t2_hold_no_s", s_count - s_base, 0);
    hold_low = 1'b0;
    pulse_go();
    wait_done(200);
    check("t2_pc", pc, 8'h01);
    check("t2_icount", icount, 3);
    check("t2_s_pulses", s_count - s_base, 3);
    check("t2_queues", exp_fetch_q.size() + exp_issue_q.size(), 0);

    // Controller never acknowledges: timeout to ERROR, then go recovers.
    load_prog(16'hA000, 16'hE000, 16'h0000, 16'h0000);
    ack_en = 1'b0;
    exp_fetch_q.push_back(8'hFE);
    exp_issue_q.push_back({3'b101, 2'b00});
    s_base = s_count;
    pulse_go();
    wait_s(10);
    repeat (8) @(negedge clk);
    check("t3_err_early", err, 0);
    @(negedge clk);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_s_pulses", s_count - s_base, 1);
    ack_en = 1'b1;
    exp_fetch_q.push_back(8'hFE);
    exp_fetch_q.push_back(8'hFF);
    exp_issue_q.push_back({3'b101, 2'b00});
    pulse_go();
    check("t3_err_clear", err, 0);
    check("t3_busy_again", busy, 1);
    check("t3_refetch_pc", pc, 8'hFE);
    wait_done(60);
    check("t3_icount", icount, 1);

    // Reset during ACK of the second instruction.
    load_prog(16'hA000, 16'hA800, 16'hE000, 16'h0000);
    exp_fetch_q.push_back(8'hFE);
    exp_fetch_q.push_back(8'hFF);
    exp_issue_q.push_back({3'b101, 2'b00});
    exp_issue_q.push_back({3'b101, 2'b01});
    pulse_go();
    wait_s(10);
    @(negedge clk);
    wait_s(20);
    @(negedge clk);
    check("t4_pre_icount", icount, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_s", s, 0);
    check("t4_pc", pc, 8'hFE);
    check("t4_icount", icount, 0);
    check("t4_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("t4_no_fetch", mem_rd, 0);
    check("t4_queues", exp_fetch_q.size() + exp_issue_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
